// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file at the MW stage with timer-interrupt trap and mret redirect.
// Define CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret counters.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  csr_op,
    input  logic        valid_mw,
    input  logic        stall_mw,
    input  logic [31:0] pc_mw,
    input  logic        instr_retire,
    input  logic        is_mret,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        trap_taken
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mip_mtip;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        issue;
    logic        irq_pend;
    logic        mret_taken;
    logic        op_writes;
    logic        csr_we;
    logic        unused_pc_lsb;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        retire;
`else
    logic        unused_retire;
`endif

    // Current value of the addressed CSR; unmapped addresses read 0.
    always_comb begin
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            ADDR_MIE:       old_val = {24'b0, mie_mtie, 7'b0};
            ADDR_MTVEC:     old_val = mtvec;
            ADDR_MSCRATCH:  old_val = mscratch;
            ADDR_MEPC:      old_val = mepc;
            ADDR_MCAUSE:    old_val = mcause;
            ADDR_MIP:       old_val = {24'b0, mip_mtip, 7'b0};
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    old_val = mcycle[31:0];
            ADDR_MCYCLEH:   old_val = mcycle[63:32];
            ADDR_MINSTRET:  old_val = minstret[31:0];
            ADDR_MINSTRETH: old_val = minstret[63:32];
`endif
            default:        old_val = '0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            OP_RC:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr_rdata = (csr_op != OP_NONE) ? old_val : '0;

    // RS/RC with a zero operand are pure reads and must not write.
    assign op_writes  = (csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_wdata != '0));
    assign issue      = valid_mw && !stall_mw;
    assign irq_pend   = mstatus_mie && mie_mtie && mip_mtip;
    assign trap_taken = irq_pend && issue;
    assign mret_taken = is_mret && issue && !irq_pend;
    assign csr_we     = op_writes && issue && !irq_pend;

    assign redirect    = trap_taken || mret_taken;
    assign redirect_pc = trap_taken ? mtvec : (mret_taken ? mepc : '0);

    assign unused_pc_lsb = ^pc_mw[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mtvec        <= {RESET_MTVEC[31:2], 2'b00};
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
        end else begin
            mip_mtip <= timer_irq;

            // Trap outranks mret and any CSR write; mret outranks a write to mstatus.
            if (trap_taken) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_taken) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_we && csr_addr == ADDR_MSTATUS) begin
                mstatus_mie  <= new_val[3];
                mstatus_mpie <= new_val[7];
            end

            if (csr_we && csr_addr == ADDR_MIE) begin
                mie_mtie <= new_val[7];
            end
            if (csr_we && csr_addr == ADDR_MTVEC) begin
                mtvec <= {new_val[31:2], 2'b00};
            end
            if (csr_we && csr_addr == ADDR_MSCRATCH) begin
                mscratch <= new_val;
            end

            if (trap_taken) begin
                mepc   <= {pc_mw[31:2], 2'b00};
                mcause <= MCAUSE_MTI;
            end else begin
                if (csr_we && csr_addr == ADDR_MEPC) begin
                    mepc <= {new_val[31:2], 2'b00};
                end
                if (csr_we && csr_addr == ADDR_MCAUSE) begin
                    mcause <= new_val;
                end
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    assign retire = instr_retire && issue && !irq_pend;

    // A write to either half replaces that edge's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_addr == ADDR_MCYCLE) begin
                mcycle[31:0] <= new_val;
            end else if (csr_we && csr_addr == ADDR_MCYCLEH) begin
                mcycle[63:32] <= new_val;
            end else begin
                mcycle <= mcycle + 64'd1;
            end

            if (csr_we && csr_addr == ADDR_MINSTRET) begin
                minstret[31:0] <= new_val;
            end else if (csr_we && csr_addr == ADDR_MINSTRETH) begin
                minstret[63:32] <= new_val;
            end else if (retire) begin
                minstret <= minstret + 64'd1;
            end
        end
    end
`else
    assign unused_retire = instr_retire;
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus randomized checks of csr_file against a masked-register model.
// Counter expectations follow CSR_COUNTERS_EN, matching the design build.
module tb_csr_file;

    localparam logic [31:0] TB_MTVEC = 32'h0000_0100;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic        valid_mw;
    logic        stall_mw;
    logic [31:0] pc_mw;
    logic        instr_retire;
    logic        is_mret;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    always #5 clk = ~clk;

    csr_file #(.RESET_MTVEC(TB_MTVEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_op      (csr_op),
        .valid_mw    (valid_mw),
        .stall_mw    (stall_mw),
        .pc_mw       (pc_mw),
        .instr_retire(instr_retire),
        .is_mret     (is_mret),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap_taken  (trap_taken)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;
    bit ret_def = 1'b1;

    // Model: each mapped CSR is a word with a writable mask and constant read bits.
    logic [31:0] sh [logic [11:0]];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    logic [31:0] last_rdata;
    logic [31:0] last_rpc;
    logic        last_trap;
    logic [31:0] c0;
    logic [31:0] i0;

    logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'hFFF};

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0080;
            12'h305: return 32'hFFFF_FFFC;
            12'h340: return 32'hFFFF_FFFF;
            12'h341: return 32'hFFFF_FFFC;
            12'h342: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (CNT_EN) begin
            if (a == 12'hB00) return m_cycle[31:0];
            if (a == 12'hB80) return m_cycle[63:32];
            if (a == 12'hB02) return m_instret[31:0];
            if (a == 12'hB82) return m_instret[63:32];
        end
        if (sh.exists(a)) return sh[a] | ((a == 12'h300) ? 32'h0000_1800 : 32'h0);
        return 32'h0;
    endfunction

    task automatic model_reset();
        sh.delete();
        sh[12'h300] = '0;
        sh[12'h304] = '0;
        sh[12'h305] = TB_MTVEC;
        sh[12'h340] = '0;
        sh[12'h341] = '0;
        sh[12'h342] = '0;
        sh[12'h344] = '0;
        m_cycle     = '0;
        m_instret   = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, n_step, obs, exp);
        end
    endtask

    // Compare outputs mid-cycle, advance the model, then cross one rising edge.
    task automatic step();
        logic        pend, issue, trap, mret, wr;
        logic [31:0] old, wv, ms, mi, mp, exp_rpc;
        logic [63:0] nc, ni;
        #2;
        n_step++;
        ms = sh[12'h300];
        mi = sh[12'h304];
        mp = sh[12'h344];
        issue   = valid_mw && !stall_mw;
        pend    = ms[3] && mi[7] && mp[7];
        trap    = pend && issue;
        mret    = is_mret && issue && !trap;
        exp_rpc = trap ? m_read(12'h305) : (mret ? m_read(12'h341) : 32'h0);
        last_rdata = csr_rdata;
        last_rpc   = redirect_pc;
        last_trap  = trap_taken;
        check("rdata", csr_rdata, (csr_op != 2'b00) ? m_read(csr_addr) : 32'h0);
        check("trap_taken", {31'b0, trap_taken}, {31'b0, trap});
        check("redirect", {31'b0, redirect}, {31'b0, trap || mret});
        check("redirect_pc", redirect_pc, exp_rpc);

        if (rst) begin
            model_reset();
        end else begin
            old = m_read(csr_addr);
            case (csr_op)
                2'b01:   wv = csr_wdata;
                2'b10:   wv = old | csr_wdata;
                2'b11:   wv = old & ~csr_wdata;
                default: wv = old;
            endcase
            wr = issue && !trap && csr_op != 2'b00 && (csr_op == 2'b01 || csr_wdata != 0);
            nc = m_cycle + 64'd1;
            ni = m_instret + ((instr_retire && issue && !trap) ? 64'd1 : 64'd0);
            if (trap) begin
                sh[12'h341] = pc_mw & ~32'h3;
                sh[12'h342] = 32'h8000_0007;
                ms[7] = ms[3];
                ms[3] = 1'b0;
            end else if (mret) begin
                ms[3] = ms[7];
                ms[7] = 1'b1;
            end
            sh[12'h300] = ms;
            if (wr) begin
                if (CNT_EN && csr_addr == 12'hB00) nc = {m_cycle[63:32], wv};
                else if (CNT_EN && csr_addr == 12'hB80) nc = {wv, m_cycle[31:0]};
                else if (CNT_EN && csr_addr == 12'hB02) ni = {m_instret[63:32], wv};
                else if (CNT_EN && csr_addr == 12'hB82) ni = {wv, m_instret[31:0]};
                else if (sh.exists(csr_addr))
                    sh[csr_addr] = (sh[csr_addr] & ~wmask(csr_addr)) | (wv & wmask(csr_addr));
            end
            sh[12'h344] = timer_irq ? 32'h0000_0080 : 32'h0;
            m_cycle   = nc;
            m_instret = ni;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        rst = 1'b0; csr_op = op; csr_addr = a; csr_wdata = d;
        valid_mw = 1'b1; stall_mw = 1'b0; is_mret = 1'b0; instr_retire = ret_def;
        step();
    endtask

    initial begin
        rst = 1'b1; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0; valid_mw = 1'b0;
        stall_mw = 1'b0; pc_mw = '0; instr_retire = 1'b0; is_mret = 1'b0; timer_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();

        // Reset values of every address
        for (int k = 0; k < 13; k++) instr(2'b10, addrs[k], 32'h0);
        instr(2'b10, 12'h305, 32'h0);
        check("reset_mtvec", last_rdata, TB_MTVEC);
        instr(2'b10, 12'h300, 32'h0);
        check("reset_mstatus", last_rdata, 32'h0000_1800);

        // mscratch RW then RS
        instr(2'b01, 12'h340, 32'hDEAD_BEEF);
        instr(2'b10, 12'h340, 32'h0000_0010);
        check("mscratch_rs_old", last_rdata, 32'hDEAD_BEEF);
        instr(2'b10, 12'h340, 32'h0);
        check("mscratch_new", last_rdata, 32'hDEAD_BEFF);
        instr(2'b11, 12'h340, 32'h0000_00FF);
        instr(2'b01, 12'h123, 32'hFFFF_FFFF);
        instr(2'b01, 12'h344, 32'hFFFF_FFFF);
        instr(2'b10, 12'h123, 32'h0);
        check("unmapped_read", last_rdata, 32'h0);

        // Field masks
        instr(2'b01, 12'h305, 32'h0000_1003);
        instr(2'b10, 12'h305, 32'h0);
        check("mtvec_mask", last_rdata, 32'h0000_1000);
        instr(2'b01, 12'h300, 32'hFFFF_FFFF);
        instr(2'b10, 12'h300, 32'h0);
        check("mstatus_mask", last_rdata, 32'h0000_1888);
        instr(2'b01, 12'h304, 32'h0000_0080);

        // Timer interrupt: trap lands on the second edge after timer_irq rises
        timer_irq = 1'b1; pc_mw = 32'h0000_0040;
        instr(2'b00, 12'h0, 32'h0);
        check("trap_early", {31'b0, last_trap}, 32'h0);
        instr(2'b00, 12'h0, 32'h0);
        check("trap_taken", {31'b0, last_trap}, 32'h1);
        check("trap_pc", last_rpc, 32'h0000_1000);
        timer_irq = 1'b0;
        instr(2'b10, 12'h341, 32'h0);
        check("mepc", last_rdata, 32'h0000_0040);
        instr(2'b10, 12'h342, 32'h0);
        check("mcause", last_rdata, 32'h8000_0007);
        instr(2'b10, 12'h300, 32'h0);
        check("mstatus_trap", last_rdata, 32'h0000_1880);
        is_mret = 1'b1; step(); is_mret = 1'b0;
        check("mret_pc", last_rpc, 32'h0000_0040);
        instr(2'b10, 12'h300, 32'h0);
        check("mstatus_mret", last_rdata, 32'h0000_1888);

        // Stalls advance mcycle but not minstret
        ret_def = 1'b0;
        instr(2'b10, 12'hB02, 32'h0);
        i0 = last_rdata;
        instr(2'b10, 12'hB00, 32'h0);
        c0 = last_rdata;
        csr_op = 2'b00; stall_mw = 1'b1; instr_retire = 1'b1;
        repeat (3) step();
        instr(2'b10, 12'hB00, 32'h0);
        check("mcycle_stall", last_rdata, CNT_EN ? c0 + 32'd4 : 32'h0);
        instr(2'b10, 12'hB02, 32'h0);
        check("minstret_stall", last_rdata, i0);
        ret_def = 1'b1;

        // 64-bit wrap of mcycle
        instr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        instr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        instr(2'b10, 12'hB80, 32'h0);
        check("mcycleh_full", last_rdata, CNT_EN ? 32'hFFFF_FFFF : 32'h0);
        instr(2'b10, 12'hB00, 32'h0);
        check("mcycle_wrap_lo", last_rdata, 32'h0);
        instr(2'b10, 12'hB80, 32'h0);
        check("mcycle_wrap_hi", last_rdata, 32'h0);

        // Pending interrupt held off by stall
        timer_irq = 1'b1; pc_mw = 32'h0000_0080;
        csr_op = 2'b00; valid_mw = 1'b1; stall_mw = 1'b1;
        repeat (4) begin
            step();
            check("stall_no_trap", {31'b0, last_trap}, 32'h0);
        end
        stall_mw = 1'b0;
        step();
        check("trap_after_stall", {31'b0, last_trap}, 32'h1);
        instr(2'b10, 12'h341, 32'h0);
        check("mepc_stall", last_rdata, 32'h0000_0080);
        is_mret = 1'b1; step(); is_mret = 1'b0;

        // Reset on a trap edge wins over the trap update
        rst = 1'b1; step();
        check("trap_in_reset", {31'b0, last_trap}, 32'h1);
        timer_irq = 1'b0;
        instr(2'b10, 12'h341, 32'h0);
        check("mepc_after_rst", last_rdata, 32'h0);
        instr(2'b10, 12'h300, 32'h0);
        check("mstatus_after_rst", last_rdata, 32'h0000_1800);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst          = ($urandom_range(0, 99) == 0);
            csr_op       = 2'($urandom_range(0, 3));
            csr_addr     = addrs[$urandom_range(0, 12)];
            csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            valid_mw     = ($urandom_range(0, 7) != 0);
            stall_mw     = ($urandom_range(0, 3) == 0);
            instr_retire = 1'($urandom_range(0, 1));
            is_mret      = (csr_op == 2'b00) && ($urandom_range(0, 7) == 0);
            timer_irq    = ($urandom_range(0, 2) == 0);
            pc_mw        = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
